dec_onehot2bin: RTL
===================

Name: dec_onehot2bin

Overview:
Registered one-hot-to-binary decoder. It is the receive-side counterpart of the binary-to-one-hot encoder and recovers the index from a one-hot word.
- Input and output both use a valid/ready handshake.
- Malformed words (zero-hot or multi-hot) are flagged and counted.
- A 2-entry output buffer absorbs downstream backpressure without a combinational ready path.

Parameters:
ONEHOT_W, 15, width of the one-hot input word
BIN_W, 4, width of the binary output; must satisfy 2**BIN_W >= ONEHOT_W
ERRCNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word this cycle
in  input  ONEHOT_W  one-hot input word
out_valid  output  1  decoded result valid (buffer non-empty)
out_ready  input  1  downstream accepts the result
out  output  BIN_W  decoded binary index
out_err  output  1  result came from a malformed input word
err_cnt  output  ERRCNT_W  saturating count of malformed words accepted

Behaviour:
- Reset (rst=0, asynchronous): buffer emptied, all in-flight words discarded.
  - out_valid=0, out=0, out_err=0, err_cnt=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-operation behaves identically; no partial state survives.
- Accept: a word is accepted on a rising edge where in_valid=1 and in_ready=1. The input is ignored otherwise.
- Decode of an accepted word:
  - Exactly one bit k set: result = k, err = 0.
  - No bits set: result = 0, err = 1.
  - More than one bit set: result = index of the lowest set bit, err = 1.
  - result is zero-extended to BIN_W.
- Buffer:
  - 2-entry FIFO of {result, err}; occupancy count 0..2 held in a register.
  - in_ready = (count < 2). It is derived only from registered state, never from out_ready or in_valid.
  - out_valid = (count > 0). out/out_err present the head entry.
  - When out_valid=0, out=0 and out_err=0.
  - Pop on a rising edge where out_valid=1 and out_ready=1.
- Latency: a word accepted at edge N is visible on out/out_valid from edge N onward, i.e. in the cycle after acceptance. The minimum latency is 1 cycle. Sustained throughput is 1 word/cycle when out_ready stays 1.
- Simultaneous events:
  - count=0, push only: count becomes 1.
  - count=1, push and pop: count stays 1; the new word becomes head on the next cycle.
  - count=2: in_ready=0, so only a pop is possible; count becomes 1.
  - Pop with count=0 cannot occur because out_valid=0.
- Stability: while out_valid=1 and out_ready=0, out and out_err hold their values and the FIFO order is preserved.
- err_cnt:
  - Increments by 1 on each accepted word with err=1, at the acceptance edge.
  - Saturates at 2**ERRCNT_W-1 and does not wrap.
  - Cleared only by reset.
- No X propagation: in is sampled only when in_valid=1 and in_ready=1.

Test Plan:
- Reset: drive rst=0 with in_valid=1, in=15'h0001 -> out_valid=0, out=0, out_err=0, err_cnt=0, no word accepted. After rst=1, in_ready=1.
- Single decodes with out_ready=1: send in=15'h0001, 15'h0080, 15'h4000 on consecutive cycles -> out=0, 7, 14, each one cycle after acceptance, out_err=0, back-to-back out_valid=1.
- Malformed words: send in=15'h0000 and then 15'h0014 -> out=0 with out_err=1, then out=2 with out_err=1; err_cnt=2.
- Backpressure: out_ready=0, send in=15'h0002, 15'h0008, 15'h0020.
  - First two accepted; in_ready=0 after two acceptances; third held by the source.
  - out=1 stays stable.
  - Raise out_ready -> outputs 1, 3, 5 in order, no loss or duplication.
- Simultaneous push/pop: count=1, in_valid=1 and out_ready=1 for 10 cycles with indices 0..9 -> count stays 1, outputs 0..9 in order.
- Saturation and reset mid-operation:
  - 300 accepted zero-hot words -> err_cnt holds 255.
  - Assert rst with count=2 -> out_valid=0 and err_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dec_onehot2bin.sv
// dec_onehot2bin
//   Registered one-hot to binary decoder with valid/ready on both sides.
//   Each accepted word is decoded to the index of its lowest set bit and
//   tagged with an error flag when the word is not exactly one-hot (zero-hot
//   or multi-hot). Results go into a 2-entry FIFO so that in_ready depends
//   only on registered occupancy, never on out_ready.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   input word valid
//   in_ready   room in the result buffer (count < 2)
//   in         one-hot input word
//   out_valid  result buffer non-empty
//   out_ready  downstream accepts the head result
//   out        decoded index of head entry (0 when empty)
//   out_err    head entry came from a malformed word (0 when empty)
//   err_cnt    saturating count of malformed words accepted
//
// BIN_W must satisfy 2**BIN_W >= ONEHOT_W.

module dec_onehot2bin #(
    parameter int ONEHOT_W = 15,
    parameter int BIN_W    = 4,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ONEHOT_W-1:0] in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIN_W-1:0]    out,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    typedef struct packed {
        logic [BIN_W-1:0] res;
        logic             err;
    } entry_t;

    logic [1:0]          r_cnt;
    logic                r_wr;
    logic                r_rd;
    entry_t              r_mem [2];
    logic [ERRCNT_W-1:0] r_err_cnt;

    entry_t w_dec;
    logic   w_zero;
    logic   w_multi;
    logic   w_push;
    logic   w_pop;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        w_dec = '0;
        for (int i = ONEHOT_W - 1; i >= 0; i--) begin
            if (in[i]) w_dec.res = BIN_W'(i);
        end
        w_zero    = (in == '0);
        // Clearing the lowest set bit leaves something only if two or more were set.
        w_multi   = |(in & (in - ONEHOT_W'(1)));
        w_dec.err = w_zero | w_multi;
    end

    assign in_ready  = (r_cnt != 2'd2);
    assign out_valid = (r_cnt != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out     = out_valid ? r_mem[r_rd].res : '0;
    assign out_err = out_valid ? r_mem[r_rd].err : 1'b0;
    assign err_cnt = r_err_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 2'd0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_err_cnt <= '0;
        end else begin
            // The decoded word is only stored on acceptance, so an X on an
            // idle input never reaches state.
            if (w_push) begin
                r_mem[r_wr] <= w_dec;
                r_wr        <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase

            if (w_push && w_dec.err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
        end
    end

endmodule
